uart_bus_ctrl: RTL and testbench
================================

Name: uart_bus_ctrl

Overview:
Memory-mapped UART controller between the pipelined MIPS MEM stage and the UART receiver/transmitter cores. It buffers received bytes in a small RX FIFO and sequences transmit requests through a holding register and a TX handshake FSM. It exposes TXD/RXD/CON registers to load/store instructions and raises an interrupt request line to the CPU.

Parameters:
FIFO_DEPTH, 4, RX FIFO entries (power of two, >=2)
ADDR_TXD, 32'h4000_0018, TX data register address
ADDR_RXD, 32'h4000_001C, RX data register address
ADDR_CON, 32'h4000_0020, control/status register address

Ports:
sysclk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
addr  in  32  bus byte address from MEM stage
rd  in  1  bus read strobe
wr  in  1  bus write strobe
wdata  in  32  bus write data
rdata  out  32  bus read data, combinational from addr/state
rx_valid  in  1  one-cycle pulse from UART receiver, byte ready
rx_data  in  8  received byte, valid with rx_valid
tx_start  out  1  one-cycle pulse to UART transmitter
tx_data  out  8  byte to send, held stable from tx_start until FSM returns to IDLE
tx_busy  in  1  transmitter busy flag
irq  out  1  registered interrupt request

Behaviour:
- Reset (any cycle, including mid-transfer): FIFO empty (ptrs/count 0), overrun=0, tx_done=0, hold_valid=0, enables=0, FSM IDLE, tx_start=0, tx_data=0, irq=0.
- RX push: rx_valid && count<FIFO_DEPTH -> write rx_data at wptr, wptr wraps modulo FIFO_DEPTH, count+1. Full and no pop -> byte dropped, overrun set (sticky).
- RX pop: rd && addr==ADDR_RXD && count>0 -> rptr advances on the edge, count-1. rdata={24'b0, fifo[rptr]} in that cycle. Read when empty -> rdata=0, no state change.
- Simultaneous push+pop: both take effect, count unchanged. Applies when full too: no overrun.
- TX holding register: wr && addr==ADDR_TXD && !hold_valid -> hold<=wdata[7:0], hold_valid<=1. Write while hold_valid=1 is ignored.
- TX FSM:
  - IDLE: hold_valid && !tx_busy -> tx_start=1 for 1 cycle, tx_data<=hold, hold_valid<=0, go WAIT_HI.
  - WAIT_HI: tx_busy==1 -> WAIT_LO.
  - WAIT_LO: tx_busy==0 -> IDLE, tx_done<=1 (sticky).
  - A new TXD write is accepted during WAIT_HI/WAIT_LO, so one byte can be queued behind the active one.
- CON read: [0] rx_not_empty, [1] hold_valid, [2] FSM!=IDLE, [3] overrun, [4] tx_done, [10:8] count (zero-extended), [16] rx_irq_en, [17] tx_irq_en, all other bits 0.
- CON write: bits 16/17 load the enables. Writing 1 to bit 3 or bit 4 clears that flag (W1C). A set event in the same cycle wins over the clear.
- irq <= (rx_irq_en && count>0) || (tx_irq_en && tx_done), registered with 1-cycle latency.
- Reads of any other address -> rdata=0. rd/wr to other addresses have no effect. rd and wr together at the same address: both effects apply.

Test Plan:
- Reset then idle: rdata at CON=0, irq=0, tx_start=0 for 20 cycles.
- rx_valid pulses with 0x0C then 0x08, then CON read -> 0x0000_0201. RXD reads return 0x0C then 0x08, then CON read -> 0.
- 5 rx_valid pulses (0x01..0x05) with no reads -> count=4, overrun=1. RXD reads yield 0x01..0x04. Writing CON=0x8 clears overrun.
- FIFO full with rx_valid coinciding with an RXD read -> old head returned, count stays 4, overrun stays 0, new byte appears last.
- TXD write 0x41 with tx_busy low -> tx_start pulse next cycle with tx_data=0x41. Model busy high 10 cycles -> tx_done=1. Set tx_irq_en -> irq=1 one cycle after the enable write.
- TXD writes 0x41, 0x42, 0x43 back-to-back during an active send -> 0x42 queued, 0x43 ignored. Then assert Reset mid-transfer -> FSM IDLE, hold cleared, no further tx_start.

Source files
------------

// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART controller: RX byte FIFO, TX holding register with a
// start/busy handshake FSM, and a CON status/control register with interrupt.
module uart_bus_ctrl #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] ADDR_TXD   = 32'h4000_0018,
    parameter logic [31:0] ADDR_RXD   = 32'h4000_001C,
    parameter logic [31:0] ADDR_CON   = 32'h4000_0020
) (
    input  logic        sysclk,
    input  logic        Reset,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_HI, S_WAIT_LO} tx_state_e;

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          tx_done_q, tx_done_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_valid_q, hold_valid_d;
    logic          rx_en_q, rx_en_d, tx_en_q, tx_en_d;
    tx_state_e     state_q, state_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          irq_q, irq_d;

    logic sel_txd, sel_rxd, sel_con;
    logic full, push, pop, overrun_set, tx_done_set, consume, con_wr;
    logic [31:0] con_val, cnt_ext;
    logic unused_wdata;

    assign sel_txd = (addr == ADDR_TXD);
    assign sel_rxd = (addr == ADDR_RXD);
    assign sel_con = (addr == ADDR_CON);
    assign con_wr  = wr && sel_con;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign pop         = rd && sel_rxd && (count_q != '0);
    assign push        = rx_valid && (!full || pop);
    assign overrun_set = rx_valid && full && !pop;

    assign cnt_ext      = 32'(count_q);
    assign unused_wdata = ^{wdata[31:18], wdata[15:5], wdata[2:0], cnt_ext[31:3]};

    always_comb begin
        con_val        = '0;
        con_val[0]     = (count_q != '0);
        con_val[1]     = hold_valid_q;
        con_val[2]     = (state_q != S_IDLE);
        con_val[3]     = overrun_q;
        con_val[4]     = tx_done_q;
        con_val[10:8]  = cnt_ext[2:0];
        con_val[16]    = rx_en_q;
        con_val[17]    = tx_en_q;
    end

    always_comb begin
        rdata = '0;
        if (sel_rxd && count_q != '0) rdata = {24'b0, fifo_q[rptr_q]};
        else if (sel_con)             rdata = con_val;
    end

    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // TX handshake FSM; tx_start/tx_data are registered so data is valid with the pulse.
    always_comb begin
        state_d     = state_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        consume     = 1'b0;
        tx_done_set = 1'b0;
        case (state_q)
            S_IDLE: if (hold_valid_q && !tx_busy) begin
                tx_start_d = 1'b1;
                tx_data_d  = hold_q;
                consume    = 1'b1;
                state_d    = S_WAIT_HI;
            end
            S_WAIT_HI: if (tx_busy) state_d = S_WAIT_LO;
            S_WAIT_LO: if (!tx_busy) begin
                state_d     = S_IDLE;
                tx_done_set = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (consume) begin
            hold_valid_d = 1'b0;
        end else if (wr && sel_txd && !hold_valid_q) begin
            hold_d       = wdata[7:0];
            hold_valid_d = 1'b1;
        end
        rx_en_d   = con_wr ? wdata[16] : rx_en_q;
        tx_en_d   = con_wr ? wdata[17] : tx_en_q;
        // Set events take priority over write-one-to-clear.
        overrun_d = overrun_set || (overrun_q && !(con_wr && wdata[3]));
        tx_done_d = tx_done_set || (tx_done_q && !(con_wr && wdata[4]));
        irq_d     = (rx_en_q && count_q != '0) || (tx_en_q && tx_done_q);
    end

    always_ff @(posedge sysclk) begin
        if (push) fifo_q[wptr_q] <= rx_data;
    end

    always_ff @(posedge sysclk) begin
        if (Reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            tx_done_q    <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            rx_en_q      <= 1'b0;
            tx_en_q      <= 1'b0;
            state_q      <= S_IDLE;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            irq_q        <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            tx_done_q    <= tx_done_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            rx_en_q      <= rx_en_d;
            tx_en_q      <= tx_en_d;
            state_q      <= state_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            irq_q        <= irq_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Directed bench for uart_bus_ctrl with a simple transmitter busy model.
module tb_uart_bus_ctrl;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        sysclk = 1'b0;
    logic        Reset, rd, wr, rx_valid, tx_busy, tx_start, irq;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  rx_data, tx_data;

    int checks = 0;
    int failures = 0;
    int busy_cnt = 0;
    int start_cnt = 0;
    logic [7:0] start_log [$];

    uart_bus_ctrl dut (
        .sysclk(sysclk), .Reset(Reset), .addr(addr), .rd(rd), .wr(wr),
        .wdata(wdata), .rdata(rdata), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .irq(irq)
    );

    always #5 sysclk = ~sysclk;

    // Transmitter: busy for 10 cycles after each start pulse.
    always @(negedge sysclk) begin
        if (tx_start) begin
            start_cnt <= start_cnt + 1;
            start_log.push_back(tx_data);
            busy_cnt  <= 10;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign tx_busy = (busy_cnt > 0);

    task automatic tick();
        @(posedge sysclk); #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1; #1;
        d = rdata;
        tick();
        rd = 1'b0; addr = '0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0; rx_data = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; rd = 0; wr = 0; addr = '0; wdata = '0; rx_valid = 0; rx_data = '0;
        repeat (3) tick();
        Reset = 1'b0;
        addr = A_CON;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if ({rdata, irq, tx_start} !== 34'b0) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: con=%h irq=%b start=%b required 0", i, rdata, irq, tx_start);
            end
            tick();
        end
        checks++;
        if (tx_data !== 8'h00) begin
            failures++; $display("FAIL reset_txdata: got %h required 00", tx_data);
        end
        addr = '0;
    endtask

    task automatic test_rx_basic();
        logic [31:0] d;
        rx_push(8'h0C); rx_push(8'h08);
        bus_read(A_CON, d); checks++;
        if (d !== 32'h0000_0201) begin failures++; $display("FAIL rx_con2: got %h required 00000201", d); end
        bus_read(A_RXD, d); checks++;
        if (d !== 32'h0C) begin failures++; $display("FAIL rx_rd0: got %h required 0000000c", d); end
        bus_read(A_RXD, d); checks++;
        if (d !== 32'h08) begin failures++; $display("FAIL rx_rd1: got %h required 00000008", d); end
        bus_read(A_CON, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL rx_con_empty: got %h required 0", d); end
        bus_read(A_RXD, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL rx_rd_empty: got %h required 0", d); end
        bus_read(A_CON, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL rx_empty_nochange: got %h required 0", d); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        for (int i = 1; i <= 5; i++) rx_push(8'(i));
        bus_read(A_CON, d); checks++;
        if (d !== 32'h0000_0409) begin failures++; $display("FAIL ovr_con: got %h required 00000409", d); end
        for (int i = 1; i <= 4; i++) begin
            bus_read(A_RXD, d); checks++;
            if (d !== 32'(i)) begin failures++; $display("FAIL ovr_rd%0d: got %h required %h", i, d, 32'(i)); end
        end
        bus_read(A_CON, d); checks++;
        if (d !== 32'h8) begin failures++; $display("FAIL ovr_sticky: got %h required 00000008", d); end
        bus_write(A_CON, 32'h8);
        bus_read(A_CON, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL ovr_w1c: got %h required 0", d); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) rx_push(8'h10 + 8'(i));
        addr = A_RXD; rd = 1'b1; rx_valid = 1'b1; rx_data = 8'h14; #1;
        d = rdata;
        tick();
        rd = 1'b0; rx_valid = 1'b0; addr = '0;
        checks++;
        if (d !== 32'h10) begin failures++; $display("FAIL pp_head: got %h required 00000010", d); end
        bus_read(A_CON, d); checks++;
        if (d !== 32'h0000_0401) begin failures++; $display("FAIL pp_con: got %h required 00000401", d); end
        for (int i = 1; i <= 4; i++) begin
            bus_read(A_RXD, d); checks++;
            if (d !== 32'h10 + 32'(i)) begin
                failures++; $display("FAIL pp_rd%0d: got %h required %h", i, d, 32'h10 + 32'(i));
            end
        end
    endtask

    task automatic test_other_addr();
        logic [31:0] d;
        rx_push(8'h77);
        bus_write(32'h4000_0024, 32'hFFFF_FFFF);
        bus_read(32'h4000_0024, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL other_rd: got %h required 0", d); end
        bus_read(A_CON, d); checks++;
        if (d !== 32'h0000_0101) begin failures++; $display("FAIL other_noeffect: got %h required 00000101", d); end
        bus_read(A_RXD, d);
    endtask

    task automatic test_rx_irq();
        logic [31:0] d;
        bus_write(A_CON, 32'h0001_0000);
        rx_push(8'h55); checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rxirq_lat: got %b required 0", irq); end
        tick(); checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL rxirq_set: got %b required 1", irq); end
        bus_read(A_RXD, d);
        tick(); checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rxirq_clr: got %b required 0", irq); end
        bus_write(A_CON, 32'h0);
    endtask

    task automatic test_tx_single();
        logic [31:0] d;
        int s0, n;
        s0 = start_cnt;
        bus_write(A_TXD, 32'h41);
        addr = A_CON; #1; checks++;
        if ({tx_start, rdata} !== {1'b0, 32'h2}) begin
            failures++; $display("FAIL tx_hold: start=%b con=%h required 0/00000002", tx_start, rdata);
        end
        tick(); checks++;
        if ({tx_start, tx_data, rdata} !== {1'b1, 8'h41, 32'h4}) begin
            failures++; $display("FAIL tx_start: start=%b data=%h con=%h required 1/41/00000004", tx_start, tx_data, rdata);
        end
        tick(); checks++;
        if (tx_start !== 1'b0) begin failures++; $display("FAIL tx_pulse_width: got %b required 0", tx_start); end
        n = 0;
        while (rdata[2] && n < 40) begin tick(); n++; end
        checks++;
        if (n >= 40) begin failures++; $display("FAIL tx_timeout: fsm busy after %0d cycles", n); end
        checks++;
        if (rdata !== 32'h10) begin failures++; $display("FAIL tx_done: got %h required 00000010", rdata); end
        checks++;
        if (start_cnt - s0 !== 1) begin failures++; $display("FAIL tx_count: got %0d required 1", start_cnt - s0); end
        bus_write(A_CON, 32'h0002_0000); checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL txirq_lat: got %b required 0", irq); end
        tick(); checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL txirq_set: got %b required 1", irq); end
        bus_write(A_CON, 32'h0002_0010);
        bus_read(A_CON, d); checks++;
        if (d !== 32'h0002_0000) begin failures++; $display("FAIL txdone_w1c: got %h required 00020000", d); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL txirq_clr: got %b required 0", irq); end
        bus_write(A_CON, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int s0, n;
        s0 = start_cnt;
        bus_write(A_TXD, 32'h41);
        tick();
        bus_write(A_TXD, 32'h42);
        bus_write(A_TXD, 32'h43);
        bus_read(A_CON, d); checks++;
        if (d !== 32'h6) begin failures++; $display("FAIL b2b_queued: got %h required 00000006", d); end
        addr = A_CON; #1;
        n = 0;
        while ((rdata[2] || rdata[1]) && n < 80) begin tick(); n++; end
        checks++;
        if (n >= 80) begin failures++; $display("FAIL b2b_timeout: fsm busy after %0d cycles", n); end
        checks++;
        if (rdata !== 32'h10) begin failures++; $display("FAIL b2b_con: got %h required 00000010", rdata); end
        addr = '0;
        checks++;
        if (start_cnt - s0 !== 2) begin
            failures++; $display("FAIL b2b_count: got %0d required 2", start_cnt - s0);
        end else begin
            checks++;
            if ({start_log[start_log.size()-2], start_log[start_log.size()-1]} !== 16'h4142) begin
                failures++; $display("FAIL b2b_bytes: got %h %h required 41 42",
                    start_log[start_log.size()-2], start_log[start_log.size()-1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int s0;
        bus_write(A_TXD, 32'h41);
        tick();
        bus_write(A_TXD, 32'h42);
        tick();
        bus_read(A_CON, d); checks++;
        if (d[2:1] !== 2'b11) begin failures++; $display("FAIL mid_pre: got %h required bits[2:1]=11", d); end
        Reset = 1'b1; tick(); Reset = 1'b0;
        addr = A_CON; #1; checks++;
        if ({rdata, tx_start, tx_data, irq} !== 42'b0) begin
            failures++; $display("FAIL mid_reset: con=%h start=%b data=%h irq=%b required 0", rdata, tx_start, tx_data, irq);
        end
        addr = '0;
        s0 = start_cnt;
        repeat (30) tick();
        checks++;
        if (start_cnt !== s0) begin failures++; $display("FAIL mid_nostart: got %0d starts required 0", start_cnt - s0); end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_overrun();
        test_push_pop_full();
        test_other_addr();
        test_rx_irq();
        test_tx_single();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
